// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 configuration sequencer and its ROM tables.
// Holds the marker encodings, the sequencer state type and the ROM word classifier.
package ov7670_cfg_pkg;

  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY     = 16'hFFF0;
  localparam logic [7:0]  CFG_LDELAY_HI = 8'hFE;
  localparam logic [7:0]  CFG_RSVD_HI   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY,
    ST_DONE
  } cfg_state_t;

  typedef enum logic [1:0] {
    OP_WRITE,
    OP_DELAY,
    OP_SKIP,
    OP_END
  } cfg_op_t;

  // FE00 is a zero-length delay, so it is treated like a reserved word.
  function automatic cfg_op_t cfg_classify(input logic [15:0] word);
    cfg_op_t op;
    if (word == CFG_END)
      op = OP_END;
    else if (word == CFG_DELAY)
      op = OP_DELAY;
    else if (word[15:8] == CFG_LDELAY_HI)
      op = (word[7:0] == 8'h00) ? OP_SKIP : OP_DELAY;
    else if (word[15:8] == CFG_RSVD_HI)
      op = OP_SKIP;
    else
      op = OP_WRITE;
    return op;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter; expire pulses during the last of 'load_val' cycles.
// A load value of N therefore keeps the caller waiting exactly N cycles.
module cfg_delay_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - CNT_W'(1);
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks a per-profile configuration ROM and issues SCCB register writes over a
// valid/ready handshake, honouring end, short-delay and long-delay markers.
module ov7670_config_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned INDEX_W      = 8,
  parameter int unsigned PROFILE_W    = 1,
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned DELAY_CYCLES = 2_500_000,
  parameter int unsigned DELAY_UNIT   = 250_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PROFILE_W-1:0]         profile_sel,
  output logic [PROFILE_W+INDEX_W-1:0] rom_addr,
  input  logic [15:0]                  rom_data,
  output logic                         sccb_valid,
  input  logic                         sccb_ready,
  output logic [7:0]                   sccb_reg,
  output logic [7:0]                   sccb_val,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic [INDEX_W:0]             wr_count
);

  localparam int unsigned MAX_DLY = (DELAY_CYCLES > 255 * DELAY_UNIT) ?
                                    DELAY_CYCLES : 255 * DELAY_UNIT;
  localparam int unsigned DLY_W   = $clog2(MAX_DLY + 1);
  localparam int unsigned LAT_W   = $clog2(ROM_LAT + 1);

  cfg_state_t           state, state_nxt;
  cfg_op_t              op;
  logic [PROFILE_W-1:0] profile_q;
  logic [INDEX_W-1:0]   index_q;
  logic [LAT_W-1:0]     lat_cnt;
  logic [INDEX_W:0]     wr_count_q;
  logic                 overrun_q;
  logic [7:0]           reg_q, val_q;
  logic                 advance, last_idx, start_acc, handshake;
  logic                 dly_load, dly_expire;
  logic [DLY_W-1:0]     dly_load_val;

  assign op        = cfg_classify(rom_data);
  assign last_idx  = (index_q == '1);
  assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
  assign handshake = (state == ST_WRITE) && sccb_ready;

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_FETCH;
      ST_FETCH:  if (lat_cnt == LAT_W'(ROM_LAT - 1)) state_nxt = ST_DECODE;
      ST_DECODE: begin
        unique case (op)
          OP_END:   state_nxt = ST_DONE;
          OP_DELAY: state_nxt = ST_DELAY;
          OP_WRITE: state_nxt = ST_WRITE;
          default:  advance   = 1'b1;
        endcase
      end
      ST_WRITE:  if (sccb_ready) advance = 1'b1;
      ST_DELAY:  if (dly_expire) advance = 1'b1;
      default:   state_nxt = ST_IDLE;
    endcase
    // The last index of a profile ends the run instead of spilling into the next one.
    if (advance)
      state_nxt = last_idx ? ST_DONE : ST_FETCH;
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    sccb_valid   = 1'b0;
    dly_load     = 1'b0;
    dly_load_val = '0;
    unique case (state)
      ST_FETCH:  busy = 1'b1;
      ST_DECODE: begin
        busy         = 1'b1;
        dly_load     = (op == OP_DELAY);
        dly_load_val = (rom_data == CFG_DELAY) ? DLY_W'(DELAY_CYCLES) :
                       DLY_W'(rom_data[7:0]) * DLY_W'(DELAY_UNIT);
      end
      ST_WRITE: begin
        busy       = 1'b1;
        sccb_valid = 1'b1;
      end
      ST_DELAY:  busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      profile_q  <= '0;
      index_q    <= '0;
      lat_cnt    <= '0;
      wr_count_q <= '0;
      overrun_q  <= 1'b0;
      reg_q      <= '0;
      val_q      <= '0;
    end else begin
      lat_cnt <= (state == ST_FETCH) ? lat_cnt + LAT_W'(1) : '0;
      if (start_acc) begin
        profile_q  <= profile_sel;
        index_q    <= '0;
        wr_count_q <= '0;
        overrun_q  <= 1'b0;
      end
      if (state == ST_DECODE && op == OP_WRITE) begin
        reg_q <= rom_data[15:8];
        val_q <= rom_data[7:0];
      end
      if (handshake && wr_count_q != '1)
        wr_count_q <= wr_count_q + (INDEX_W + 1)'(1);
      if (advance) begin
        if (last_idx)
          overrun_q <= 1'b1;
        else
          index_q <= index_q + INDEX_W'(1);
      end
    end
  end

  cfg_delay_timer #(
    .CNT_W (DLY_W)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_load_val),
    .expire   (dly_expire)
  );

  assign rom_addr = {profile_q, index_q};
  assign sccb_reg = reg_q;
  assign sccb_val = val_q;
  assign overrun  = overrun_q;
  assign wr_count = wr_count_q;

endmodule
